// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting exclusive write ownership of one shared WIDTH-bit register bank.
// Optional forced release after MAX_HOLD owned cycles: define DFF_BANK_ARB_TIMEOUT_EN.
module dff_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                    CLOCK,
    input  logic                    CLEAR,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         WE,
    input  logic [NREQ*WIDTH-1:0]   WDATA,
    input  logic                    CLR_Q,
    output logic [NREQ-1:0]         GNT,
    output logic [IDXW-1:0]         OWNER,
    output logic                    BUSY,
    output logic [WIDTH-1:0]        Q,
    output logic                    TIMEOUT
);

    if (NREQ < 2 || NREQ > 8 || IDXW < $clog2(NREQ) || MAX_HOLD < 2) begin : g_param_check
        $error("dff_bank_arbiter: illegal parameter set");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              found_s;
    logic [IDXW-1:0]   win_s;
    logic [IDXW-1:0]   next_ptr_s;

`ifdef DFF_BANK_ARB_TIMEOUT_EN
    logic [HW-1:0]     hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    // Rotating-priority search starting at the pointer, wrapping mod NREQ
    always_comb begin
        int idx_v;
        found_s = 1'b0;
        win_s   = {IDXW{1'b0}};
        idx_v   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(ptr_q) + k) % NREQ;
            if (!found_s && REQ[idx_v]) begin
                found_s = 1'b1;
                win_s   = IDXW'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
        if (int'(owner_q) == NREQ - 1) begin
            next_ptr_s = {IDXW{1'b0}};
        end else begin
            next_ptr_s = owner_q + {{(IDXW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state, grant and bank-write decode
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        q_d       = q_q;
`ifdef DFF_BANK_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = OWNED;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    owner_d = win_s;
                    busy_d  = 1'b1;
`ifdef DFF_BANK_ARB_TIMEOUT_EN
                    hold_d  = {HW{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            OWNED: begin
                // Release (normal or forced) never writes the bank
                if (!REQ[owner_q]
`ifdef DFF_BANK_ARB_TIMEOUT_EN
                    || (int'(hold_q) == MAX_HOLD - 1)
`endif
                ) begin
                    state_d = IDLE;
                    gnt_d   = {NREQ{1'b0}};
                    owner_d = {IDXW{1'b0}};
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr_s;
`ifdef DFF_BANK_ARB_TIMEOUT_EN
                    timeout_d = REQ[owner_q];
`endif
                end else begin
`ifdef DFF_BANK_ARB_TIMEOUT_EN
                    hold_d = hold_q + {{(HW-1){1'b0}}, 1'b1};
`endif
                    if (WE[owner_q]) begin
                        q_d = WDATA[int'(owner_q)*WIDTH +: WIDTH];
                    end else begin
                        q_d = q_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (CLR_Q) begin
            q_d = {WIDTH{1'b0}};
        end else begin
            q_d = q_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            state_q <= IDLE;
            gnt_q   <= {NREQ{1'b0}};
            owner_q <= {IDXW{1'b0}};
            ptr_q   <= {IDXW{1'b0}};
            busy_q  <= 1'b0;
            q_q     <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
        end
    end

`ifdef DFF_BANK_ARB_TIMEOUT_EN
    // Hold counter and forced-release pulse
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            hold_q    <= {HW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT   = gnt_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4).
module tb_dff_bank_arbiter;

    logic        clk;
    logic        clear;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        clr_q;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    dff_bank_arbiter #(
        .NREQ(4), .WIDTH(8), .IDXW(2), .MAX_HOLD(4)
    ) dut (
        .CLOCK(clk), .CLEAR(clear), .REQ(req), .WE(we), .WDATA(wdata),
        .CLR_Q(clr_q), .GNT(gnt), .OWNER(owner), .BUSY(busy), .Q(q),
        .TIMEOUT(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] oh;
        clear = 1'b1; req = 4'b1111; we = 4'b1111; wdata = 32'hFFFF_FFFF; clr_q = 1'b0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);

        clear = 1'b0; we = 4'b0000;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        chk("first_release", 32'(gnt), 32'h0);

        // single owner 2, write A5
        req = 4'b0100;
        tick();
        chk("own2_gnt", 32'(gnt), 32'h4);
        chk("own2_owner", 32'(owner), 32'h2);
        we = 4'b0100; wdata = 32'h00A5_0000;
        tick();
        chk("own2_write", 32'(q), 32'hA5);
        we = 4'b0000; req = 4'b0000;
        tick();
        chk("own2_rel_gnt", 32'(gnt), 32'h0);
        chk("own2_rel_busy", 32'(busy), 32'h0);
        chk("own2_rel_owner", 32'(owner), 32'h0);
        chk("own2_q_hold", 32'(q), 32'hA5);
        req = 4'b1111;
        tick();
        chk("ptr3_gnt", 32'(gnt), 32'h8);

        // owner 3 drops REQ while writing 11: no write, wrap to 0
        tick();
        chk("own3_hold", 32'(gnt), 32'h8);
        req = 4'b0110; we = 4'b1000; wdata = 32'h1100_0000;
        tick();
        chk("rel_we_gnt", 32'(gnt), 32'h0);
        chk("rel_we_q", 32'(q), 32'hA5);
        we = 4'b0000;
        tick();
        chk("wrap_gnt", 32'(gnt), 32'h2);
        chk("wrap_owner", 32'(owner), 32'h1);

        // non-owner write ignored, then CLR_Q beats owner write
        req = 4'b0011; we = 4'b0011; wdata = 32'h0000_3CFF;
        tick();
        chk("nonowner_q", 32'(q), 32'h3C);
        clr_q = 1'b1; we = 4'b0010; wdata = 32'h0000_7700;
        tick();
        chk("clrq_q", 32'(q), 32'h0);
        chk("clrq_gnt", 32'(gnt), 32'h2);
        chk("clrq_busy", 32'(busy), 32'h1);
        clr_q = 1'b0; we = 4'b0000; req = 4'b0000;
        tick();
        chk("own1_rel", 32'(gnt), 32'h0);

        // fairness with all requesting: 2,3,0,1,2
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << ((2 + i) % 4);
            req = 4'b1111;
            tick();
            chk("fair_gnt", 32'(gnt), 32'(oh));
            chk("fair_owner", 32'((2 + i) % 4), 32'(owner));
            tick();
            chk("fair_hold1", 32'(gnt), 32'(oh));
            tick();
            chk("fair_hold2", 32'(gnt), 32'(oh));
            req = 4'b1111 & ~oh;
            tick();
            chk("fair_idle", 32'(gnt), 32'h0);
            chk("fair_idle_busy", 32'(busy), 32'h0);
        end

        // CLEAR mid-ownership
        req = 4'b1111;
        tick();
        chk("pre_clr_gnt", 32'(gnt), 32'h8);
        we = 4'b1000; wdata = 32'h5A00_0000;
        tick();
        chk("pre_clr_q", 32'(q), 32'h5A);
        chk("no_timeout", 32'(timeout), 32'h0);
        clear = 1'b1;
        tick();
        chk("mid_clr_gnt", 32'(gnt), 32'h0);
        chk("mid_clr_q", 32'(q), 32'h0);
        chk("mid_clr_busy", 32'(busy), 32'h0);
        clear = 1'b0; we = 4'b0000;

`ifdef DFF_BANK_ARB_TIMEOUT_EN
        req = 4'b0011;
        tick();
        chk("to_gnt", 32'(gnt), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold", 32'(gnt), 32'h1);
            chk("to_quiet", 32'(timeout), 32'h0);
        end
        tick();
        chk("to_rel_gnt", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'h2);
        chk("to_pulse_end", 32'(timeout), 32'h0);
`else
        req = 4'b0001;
        for (int i = 0; i < 6; i++) tick();
        chk("unbounded_gnt", 32'(gnt), 32'h1);
        chk("timeout_tied", 32'(timeout), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
